// File: rtl/morph_bin_filter.sv
// rtl/morph_bin_filter.sv - KSIZE x KSIZE binary erode/dilate/bypass filter for a 1-bit pixel stream
//
// Ports:
//   pclk, rst_n          pixel clock, asynchronous active-low reset
//   mode[1:0]            0 erode, 1 dilate, 2/3 bypass; sampled at the active in_vs edge
//   in_hs/in_vs/in_de    input syncs
//   in_din               input binary pixel
//   out_hs/out_vs/out_de input syncs delayed LAT cycles (out_de gated until armed)
//   out_dout             filtered pixel, 0 while out_de is 0
//   line_ovf             sticky: a line in the current frame exceeded IMG_W pixels
module morph_bin_filter #(
    parameter int IMG_W  = 640,
    parameter int KSIZE  = 3,
    parameter bit VS_POL = 1'b1
) (
    input  logic       pclk,
    input  logic       rst_n,
    input  logic [1:0] mode,
    input  logic       in_hs,
    input  logic       in_vs,
    input  logic       in_de,
    input  logic       in_din,
    output logic       out_hs,
    output logic       out_vs,
    output logic       out_de,
    output logic       out_dout,
    output logic       line_ovf
);

    localparam int K   = KSIZE;
    localparam int LAT = 3;
    localparam int CW  = $clog2(IMG_W + 1);
    localparam int AW  = $clog2(IMG_W);

    generate
        if (KSIZE != 3 && KSIZE != 5) begin : g_bad_ksize
            $error("morph_bin_filter: KSIZE must be 3 or 5");
        end
    endgenerate

    // Input edge detection and frame/line counters
    logic          vs_act_d;
    logic          de_d;
    logic          armed;
    logic [1:0]    mode_q;
    logic [CW-1:0] col_q;
    logic [CW-1:0] col_cur;
    logic [2:0]    row_q;
    logic          vs_act;
    logic          vs_edge;
    logic          de_rise;
    logic          de_fall;
    logic          in_range;
    logic          arm_eff;
    logic          lb_we;
    logic [AW-1:0] addr;
    logic          pad;

    assign vs_act   = (in_vs == VS_POL);
    assign vs_edge  = vs_act & ~vs_act_d;
    assign de_rise  = in_de & ~de_d;
    assign de_fall  = ~in_de & de_d;
    // The first pixel of a line sees col 0 even though the register still
    // holds the previous line's end count.
    assign col_cur  = de_rise ? '0 : col_q;
    assign in_range = (col_cur < CW'(IMG_W));
    // After reset nothing is trusted until a frame boundary is seen.
    assign arm_eff  = armed | vs_edge;
    assign lb_we    = in_de & in_range & arm_eff;
    assign addr     = in_range ? col_cur[AW-1:0] : '0;
    // Neutral element of the current operation: 1 for AND, 0 for OR.
    assign pad      = (mode_q == 2'd0);

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            vs_act_d <= 1'b0;
            de_d     <= 1'b0;
            armed    <= 1'b0;
            mode_q   <= 2'd0;
            col_q    <= '0;
            row_q    <= '0;
            line_ovf <= 1'b0;
        end else begin
            vs_act_d <= vs_act;
            de_d     <= in_de;
            if (vs_edge) begin
                armed  <= 1'b1;
                mode_q <= mode;
            end
            if (in_de) begin
                col_q <= in_range ? col_cur + CW'(1) : col_cur;
            end
            if (vs_edge) begin
                row_q <= '0;
            end else if (de_fall && row_q < 3'(K - 1)) begin
                row_q <= row_q + 3'd1;
            end
            if (in_de && col_cur == CW'(IMG_W)) begin
                line_ovf <= 1'b1;
            end else if (vs_edge) begin
                line_ovf <= 1'b0;
            end
        end
    end

    // Cascaded line buffers: lb_mem[0] holds the previous line, lb_mem[d]
    // the line d+1 above. Reading and writing the same address in one cycle
    // returns the old contents, which is what pushes each line down.
    logic lb_mem [K-1][IMG_W];

    always_ff @(posedge pclk) begin
        if (lb_we) begin
            lb_mem[0][addr] <= in_din;
            for (int d = 1; d < K - 1; d++) begin
                lb_mem[d][addr] <= lb_mem[d-1][addr];
            end
        end
    end

    // Vertical column for the current pixel with row and overflow padding
    // applied before it enters the window, so padded taps travel with it.
    logic [K-1:0] vcol;

    always_comb begin
        vcol    = '0;
        vcol[0] = in_din;
        for (int d = 1; d < K; d++) begin
            if (row_q < 3'(d) || !in_range) begin
                vcol[d] = pad;
            end else begin
                vcol[d] = lb_mem[d-1][addr];
            end
        end
    end

    // Stage 1: window column shift (win[0] is the newest column)
    logic [K-1:0]   win [K];
    logic [CW-1:0]  col_s1;
    logic           de_s1;
    logic           din_s1;
    logic [1:0]     mode_s1;
    logic [LAT-1:0] hs_sr;
    logic [LAT-1:0] vs_sr;
    logic [LAT-1:0] de_sr;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < K; j++) begin
                win[j] <= '0;
            end
            col_s1  <= '0;
            de_s1   <= 1'b0;
            din_s1  <= 1'b0;
            mode_s1 <= 2'd0;
            hs_sr   <= '0;
            vs_sr   <= '0;
            de_sr   <= '0;
        end else begin
            if (in_de) begin
                win[0] <= vcol;
                for (int j = 1; j < K; j++) begin
                    win[j] <= win[j-1];
                end
            end
            col_s1  <= col_cur;
            de_s1   <= in_de & arm_eff;
            din_s1  <= in_din;
            mode_s1 <= mode_q;
            hs_sr   <= {hs_sr[LAT-2:0], in_hs};
            vs_sr   <= {vs_sr[LAT-2:0], in_vs};
            de_sr   <= {de_sr[LAT-2:0], in_de & arm_eff};
        end
    end

    // Stage 2: per-row reduction with left-edge padding
    logic [K-1:0] row_red;
    logic         pad_s1;
    logic         tap;

    assign pad_s1 = (mode_s1 == 2'd0);

    always_comb begin
        row_red = '0;
        tap     = 1'b0;
        for (int d = 0; d < K; d++) begin
            row_red[d] = pad_s1;
            for (int j = 0; j < K; j++) begin
                tap = (col_s1 < CW'(j)) ? pad_s1 : win[j][d];
                row_red[d] = (mode_s1 == 2'd0) ? (row_red[d] & tap) : (row_red[d] | tap);
            end
        end
    end

    logic [K-1:0] row_s2;
    logic         de_s2;
    logic         din_s2;
    logic [1:0]   mode_s2;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            row_s2  <= '0;
            de_s2   <= 1'b0;
            din_s2  <= 1'b0;
            mode_s2 <= 2'd0;
        end else begin
            row_s2  <= row_red;
            de_s2   <= de_s1;
            din_s2  <= din_s1;
            mode_s2 <= mode_s1;
        end
    end

    // Stage 3: final reduction across rows, blanking forces 0
    logic red_all;

    assign red_all = mode_s2[0] ? (|row_s2) : (&row_s2);

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            out_dout <= 1'b0;
        end else begin
            out_dout <= de_s2 & (mode_s2[1] ? din_s2 : red_all);
        end
    end

    assign out_hs = hs_sr[LAT-1];
    assign out_vs = vs_sr[LAT-1];
    assign out_de = de_sr[LAT-1];

endmodule
